// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: watches a two-way light controller for illegal lamps, bad phase order and,
// with TRAFFIC_MON_TIMING_CHECK_EN defined, short or long phase dwell times.
module traffic_light_monitor #(
  parameter int GREEN_CYCLE_LENGTH  = 10,
  parameter int YELLOW_CYCLE_LENGTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ns_g_i,
  input  logic        ns_y_i,
  input  logic        ns_r_i,
  input  logic        ew_g_i,
  input  logic        ew_y_i,
  input  logic        ew_r_i,
  output logic [1:0]  phase_o,
  output logic        phase_valid_o,
  output logic        err_o,
  output logic [2:0]  err_code_o,
  output logic [7:0]  err_cnt_o,
  output logic [15:0] cycle_cnt_o
);
  typedef enum logic {SYNC, TRACK} state_t;
  state_t      r_state, w_state;
  logic [1:0]  r_phase, w_phase, w_ph;
  logic        r_valid, w_valid, r_err, w_chg, w_seq, w_cycle, w_legal;
  logic [2:0]  r_code, w_err;
  logic [7:0]  r_cnt;
  logic [15:0] r_cycles;
  logic [5:0]  w_lamps;
  // dwell counter saturates at 255, so the long-phase check needs length+1 <= 255
  if (GREEN_CYCLE_LENGTH < 1 || GREEN_CYCLE_LENGTH > 254 ||
      YELLOW_CYCLE_LENGTH < 1 || YELLOW_CYCLE_LENGTH > 254) begin : g_bad_len
    $error("traffic_light_monitor: cycle lengths must be in 1..254");
  end
  assign w_lamps = {ns_g_i, ns_y_i, ns_r_i, ew_g_i, ew_y_i, ew_r_i};
  assign w_legal = w_lamps inside {6'b100001, 6'b010001, 6'b001100, 6'b001010};
  assign w_ph    = w_lamps == 6'b010001 ? 2'd1 :
                   w_lamps == 6'b001100 ? 2'd2 :
                   w_lamps == 6'b001010 ? 2'd3 : 2'd0;
  assign w_chg   = r_state == TRACK && w_ph != r_phase;
  assign w_seq   = w_ph == r_phase + 2'd1;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
  localparam logic [8:0] GREEN_LEN  = 9'(GREEN_CYCLE_LENGTH);
  localparam logic [8:0] YELLOW_LEN = 9'(YELLOW_CYCLE_LENGTH);
  logic [7:0] r_dwell, w_dwell;
  logic       r_checked, w_checked;
  logic [8:0] w_exp;
  assign w_exp = r_phase[0] ? YELLOW_LEN : GREEN_LEN;
`endif
  always_comb begin
    w_state = w_legal ? TRACK : SYNC;
    w_phase = w_legal ? w_ph : r_phase;
    w_valid = w_legal;
    w_cycle = w_legal && w_chg && w_seq && w_ph == 2'd0;
    w_err   = !w_legal ? 3'd1 : (w_chg && !w_seq) ? 3'd2 : 3'd0;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    w_dwell   = 8'd0;
    w_checked = 1'b0;
    if (w_legal && r_state == TRACK && !w_chg) begin
      w_dwell   = r_dwell + {7'd0, r_dwell != 8'hff};
      w_checked = r_checked && {1'b0, w_dwell} != w_exp + 9'd1;
      if (r_checked && !w_checked) w_err = 3'd4;
    end else if (w_legal) begin
      w_dwell   = 8'd1;
      w_checked = w_chg && w_seq;
      if (w_checked && r_checked && {1'b0, r_dwell} < w_exp) w_err = 3'd3;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SYNC;
      r_phase  <= 2'd0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= 3'd0;
      r_cnt    <= 8'd0;
      r_cycles <= 16'd0;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
      r_dwell   <= 8'd0;
      r_checked <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_valid <= w_valid;
      if (w_err != 3'd0) begin
        r_err <= 1'b1;
        if (!r_err) r_code <= w_err;
        r_cnt <= r_cnt + {7'd0, r_cnt != 8'hff};
      end
      if (w_cycle) r_cycles <= r_cycles + 16'd1;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
      r_dwell   <= w_dwell;
      r_checked <= w_checked;
`endif
    end
  end
  assign phase_o       = r_phase;
  assign phase_valid_o = r_valid;
  assign err_o         = r_err;
  assign err_code_o    = r_code;
  assign err_cnt_o     = r_cnt;
  assign cycle_cnt_o   = r_cycles;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: random and directed lamp sequences checked every cycle against a
// rule-level model of the monitor, plus literal spot checks of the documented scenarios.
module tb_traffic_light_monitor;
  localparam int G = 10;
  localparam int Y = 3;
  localparam logic [5:0] NSG = 6'b100001, NSY = 6'b010001, EWG = 6'b001100, EWY = 6'b001010;
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
  localparam bit TIM = 1'b1;
`else
  localparam bit TIM = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] lamps = 6'd0;
  logic ns_g_i, ns_y_i, ns_r_i, ew_g_i, ew_y_i, ew_r_i;
  logic [1:0] phase_o;
  logic phase_valid_o, err_o;
  logic [2:0] err_code_o;
  logic [7:0] err_cnt_o;
  logic [15:0] cycle_cnt_o;
  int n_assert = 0, n_fail = 0;
  assign {ns_g_i, ns_y_i, ns_r_i, ew_g_i, ew_y_i, ew_r_i} = lamps;
  always #5 clk = ~clk;
  traffic_light_monitor #(.GREEN_CYCLE_LENGTH(G), .YELLOW_CYCLE_LENGTH(Y)) dut (
    .clk(clk), .rst(rst),
    .ns_g_i(ns_g_i), .ns_y_i(ns_y_i), .ns_r_i(ns_r_i),
    .ew_g_i(ew_g_i), .ew_y_i(ew_y_i), .ew_r_i(ew_r_i),
    .phase_o(phase_o), .phase_valid_o(phase_valid_o), .err_o(err_o),
    .err_code_o(err_code_o), .err_cnt_o(err_cnt_o), .cycle_cnt_o(cycle_cnt_o)
  );
  function automatic int dec(input logic [5:0] l);
    case (l)
      NSG: return 0;
      NSY: return 1;
      EWG: return 2;
      EWY: return 3;
      default: return -1;
    endcase
  endfunction
  function automatic logic [5:0] pat(input int p);
    case (p)
      0: return NSG;
      1: return NSY;
      2: return EWG;
      default: return EWY;
    endcase
  endfunction
  function automatic int len(input int p);
    return (p % 2) ? Y : G;
  endfunction
  // reference model: what the outputs must read after each sampled edge
  bit m_init = 0, m_track, m_valid, m_checked, m_err;
  int m_phase, m_run, m_code, m_cnt, m_cycles;
  always @(posedge clk) begin
    int p, ev;
    if (rst) begin
      m_init = 1; m_track = 0; m_valid = 0; m_checked = 0; m_err = 0;
      m_phase = 0; m_run = 0; m_code = 0; m_cnt = 0; m_cycles = 0;
    end else if (m_init) begin
      p = dec(lamps);
      ev = 0;
      if (p < 0) begin
        ev = 1; m_valid = 0; m_track = 0;
      end else begin
        if (!m_track) begin
          m_phase = p; m_run = 1; m_checked = 0;
        end else if (p == m_phase) begin
          m_run = (m_run < 255) ? m_run + 1 : 255;
          if (TIM && m_checked && m_run == len(p) + 1) begin ev = 4; m_checked = 0; end
        end else if (p == (m_phase + 1) % 4) begin
          if (TIM && m_checked && m_run < len(m_phase)) ev = 3;
          if (p == 0) m_cycles = (m_cycles + 1) % 65536;
          m_phase = p; m_run = 1; m_checked = 1;
        end else begin
          ev = 2; m_phase = p; m_run = 1; m_checked = 0;
        end
        m_track = 1; m_valid = 1;
      end
      if (ev != 0) begin
        if (!m_err) m_code = ev;
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (m_init) begin
      check("phase", 32'(phase_o), 32'(m_phase));
      check("valid", 32'(phase_valid_o), 32'(m_valid));
      check("err", 32'(err_o), 32'(m_err));
      check("code", 32'(err_code_o), 32'(m_code));
      check("err_cnt", 32'(err_cnt_o), 32'(m_cnt));
      check("cycles", 32'(cycle_cnt_o), 32'(m_cycles));
    end
  end
  task automatic drive(input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      lamps = l;
    end
  endtask
  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    lamps = 6'($urandom);
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  task automatic pin_zero(input string tag);
    check({tag, "_phase"}, 32'(phase_o), 0);
    check({tag, "_valid"}, 32'(phase_valid_o), 0);
    check({tag, "_err"}, 32'(err_o), 0);
    check({tag, "_code"}, 32'(err_code_o), 0);
    check({tag, "_cnt"}, 32'(err_cnt_o), 0);
    check({tag, "_cycles"}, 32'(cycle_cnt_o), 0);
  endtask
  initial begin
    int rp, m;
    settle();
    pin_zero("reset");
    for (int k = 0; k < 2; k++) begin
      drive(NSG, G); drive(NSY, Y); drive(EWG, G); drive(EWY, Y);
    end
    drive(NSG, 1);
    settle();
    check("seq_err", 32'(err_o), 0);
    check("seq_cycles", 32'(cycle_cnt_o), 2);
    check("seq_phase", 32'(phase_o), 0);
    check("seq_valid", 32'(phase_valid_o), 1);
    drive(NSG, G - 1); drive(NSY, Y); drive(EWG, 4);
    drive(6'b101100, 1);
    settle();
    check("illegal_code", 32'(err_code_o), 1);
    check("illegal_valid", 32'(phase_valid_o), 0);
    check("illegal_hold", 32'(phase_o), 2);
    drive(NSG, 1);
    settle();
    check("resync_valid", 32'(phase_valid_o), 1);
    check("resync_cnt", 32'(err_cnt_o), 1);
    pulse_rst();
    drive(EWY, 1); drive(NSG, G); drive(EWG, 1);
    settle();
    check("badseq_code", 32'(err_code_o), 2);
    check("badseq_cnt", 32'(err_cnt_o), 1);
    check("badseq_phase", 32'(phase_o), 2);
    pulse_rst();
    drive(EWY, 1); drive(NSG, G); drive(NSY, Y - 1); drive(EWG, 1);
    settle();
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    check("short_code", 32'(err_code_o), 3);
`else
    check("short_err", 32'(err_o), 0);
`endif
    pulse_rst();
    drive(NSY, 1); drive(EWG, G + 1);
    settle();
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    check("long_code", 32'(err_code_o), 4);
    check("long_cnt", 32'(err_cnt_o), 1);
`else
    check("long_err", 32'(err_o), 0);
`endif
    drive(EWG, 1);
    drive(NSY, 1);
    settle();
`ifdef TRAFFIC_MON_TIMING_CHECK_EN
    check("long_then_seq_code", 32'(err_code_o), 4);
    check("long_then_seq_cnt", 32'(err_cnt_o), 2);
`else
    check("seq_only_code", 32'(err_code_o), 2);
    check("seq_only_cnt", 32'(err_cnt_o), 1);
`endif
    pulse_rst();
    settle();
    pin_zero("midrst");
    drive(6'b000000, 260);
    settle();
    check("sat_cnt", 32'(err_cnt_o), 255);
    check("sat_code", 32'(err_code_o), 1);
    pulse_rst();
    rp = 0;
    for (int k = 0; k < 400; k++) begin
      m = int'($urandom_range(0, 19));
      if (m == 0) pulse_rst();
      else if (m == 1) drive(6'($urandom), 1);
      else if (m == 2) begin
        rp = int'($urandom_range(0, 3));
        drive(pat(rp), int'($urandom_range(1, 12)));
      end else begin
        rp = (rp + 1) % 4;
        drive(pat(rp), len(rp) - 1 + int'($urandom_range(0, 2)));
      end
    end
    settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter GREEN_CYCLE_LENGTH, default 10, meaning the required green dwell in clock cycles per direction.
REQ-002 SHALL have parameter YELLOW_CYCLE_LENGTH, default 3, meaning the required yellow dwell in clock cycles per direction.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports ns_g_i, ns_y_i, ns_r_i, ew_g_i, ew_y_i, ew_r_i  input  1 each  observed lamp drives of the controller.
REQ-006 SHALL have port phase_o  output  2  decoded phase: 0 NS_GREEN, 1 NS_YELLOW, 2 EW_GREEN, 3 EW_YELLOW.
REQ-007 SHALL have port phase_valid_o  output  1  high when the last sample was a legal lamp pattern.
REQ-008 SHALL have port err_o  output  1  sticky error flag.
REQ-009 SHALL have port err_code_o  output  3  code of the first error: 0 none, 1 illegal pattern, 2 bad sequence, 3 short phase, 4 long phase.
REQ-010 SHALL have port err_cnt_o  output  8  saturating count of all error events.
REQ-011 SHALL have port cycle_cnt_o  output  16  count of completed full light cycles, wrapping.

Function
REQ-012 SHALL sample the six inputs every cycle; all outputs SHALL be registered, so a sample's effect is visible one cycle later.
REQ-013 SHALL decode exactly four legal patterns: NS_GREEN = ns_g & ew_r; NS_YELLOW = ns_y & ew_r; EW_GREEN = ew_g & ns_r; EW_YELLOW = ew_y & ns_r; all other lamps low; any other pattern SHALL be illegal.
REQ-014 SHALL implement states SYNC (no trusted phase) and TRACK (current phase known); reset enters SYNC.
REQ-015 In SYNC, a legal sample SHALL enter TRACK with that phase marked unchecked (its dwell exempt from timing checks); an illegal sample SHALL stay in SYNC and raise error 1.
REQ-016 In TRACK, an illegal sample SHALL raise error 1, drop phase_valid_o, hold phase_o, and return to SYNC.
REQ-017 In TRACK, the only legal phase changes SHALL be NS_GREEN->NS_YELLOW->EW_GREEN->EW_YELLOW->NS_GREEN; any other change SHALL raise error 2 and adopt the new phase as unchecked.
REQ-018 A dwell counter SHALL count consecutive samples of the current phase: 1 on the first sample, saturating at 255.
REQ-019 On a legal change out of a checked phase with dwell below the expected length, error 3 SHALL be raised.
REQ-020 When a checked phase is sampled for the (expected+1)th time, error 4 SHALL be raised once, and that phase SHALL become unchecked.
REQ-021 cycle_cnt_o SHALL increment on each legal EW_YELLOW->NS_GREEN change, including changes out of unchecked or erroneous phases.
REQ-022 At most one error event SHALL be recorded per cycle, with priority 1 > 2 > 3 > 4.
REQ-023 err_o and err_code_o SHALL latch the first error and hold it until reset; err_cnt_o SHALL count every event and saturate at 255.

Reset
REQ-024 On rst high at a clock edge: state SYNC, phase_o 0, phase_valid_o 0, err_o 0, err_code_o 0, err_cnt_o 0, cycle_cnt_o 0, dwell 0; inputs sampled in that cycle SHALL be ignored.
REQ-025 Reset asserted mid-phase SHALL discard all history; the first post-reset phase SHALL be unchecked.

Configuration
REQ-026 Macro TRAFFIC_MON_TIMING_CHECK_EN defined: the dwell counter and errors 3 and 4 SHALL be implemented.
REQ-027 Macro undefined: the dwell counter SHALL be omitted and codes 3/4 SHALL never occur; the decode, sequence, error 1/2 and cycle-count behaviour SHALL be unchanged.

Verification (defaults, macro defined unless noted)
REQ-028 Reset, then the sequence NSG x10, NSY x3, EWG x10, EWY x3 applied twice, then NSG x1 -> err_o 0, cycle_cnt_o 2, phase_o 0, phase_valid_o 1.
REQ-029 During EWG, ns_g_i and ew_g_i both high for 1 cycle -> next cycle err_code_o 1, phase_valid_o 0; a following NSG sample re-enters TRACK with no further error.
REQ-030 After a checked NSG of 10 cycles, apply EWG -> err_code_o 2, err_cnt_o 1, phase_o 2.
REQ-031 Checked NSY held 2 cycles, then EWG -> err_code_o 3; with the macro undefined -> err_o 0.
REQ-032 Checked EWG held 12 cycles -> error 4 one cycle after the 11th sample, err_cnt_o 1 (no second event on the 12th); then error 2 injected -> err_code_o 4, err_cnt_o 2; rst pulse -> all outputs 0.
